// File: rtl/pl_mem_bridge.sv
// Shared 256x32 memory between a PS host and a PL job engine with an IDLE/ARMED/SERVING/COMPLETE
// handshake and a SERVING watchdog. Define PL_MEM_BRIDGE_CLEAR_EN to add a post-job CLEAR sweep.
module pl_mem_bridge #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cmd,
  input  logic [7:0]  address_pl,
  input  logic [31:0] data_pl,
  input  logic        done_pl,
  output logic [31:0] data_in,
  output logic        ready,
  input  logic        ps_wr_en,
  input  logic        ps_rd_en,
  input  logic [7:0]  ps_addr,
  input  logic [31:0] ps_wdata,
  input  logic        ps_start,
  input  logic        ps_ack,
  output logic [31:0] ps_rdata,
  output logic        ps_rd_valid,
  output logic [3:0]  status
);

  localparam logic [2:0]  CMD_WRITE = 3'd2;
  localparam logic [2:0]  CMD_READ  = 3'd3;
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_SERVING  = 3'd2,
`ifdef PL_MEM_BRIDGE_CLEAR_EN
    ST_CLEAR    = 3'd4,
`endif
    ST_COMPLETE = 3'd3
  } state_e;

  logic [31:0] mem_q [256];

  state_e      state_q;
  state_e      state_d;
  logic [15:0] wdog_q;
  logic [15:0] wdog_d;
  logic [15:0] wdog_inc_s;
  logic        timeout_q;
  logic        timeout_d;
  logic        wr_err_q;
  logic        wr_err_d;
  logic        busy_q;
  logic        busy_d;
  logic        ready_q;
  logic        result_valid_q;
  logic [31:0] data_in_q;
  logic [31:0] ps_rdata_q;
  logic        ps_rd_valid_q;
`ifdef PL_MEM_BRIDGE_CLEAR_EN
  logic [7:0]  clr_addr_q;
  logic [7:0]  clr_addr_d;
`endif

  logic        pl_active_s;
  logic        pl_rd_s;
  logic        pl_wr_s;
  logic        ps_wr_ok_s;
  logic        mem_we_s;
  logic [7:0]  mem_waddr_s;
  logic [31:0] mem_wdata_s;

  assign pl_active_s = (state_q == ST_ARMED) || (state_q == ST_SERVING);
  assign pl_rd_s     = pl_active_s && (cmd == CMD_READ);
  assign pl_wr_s     = pl_active_s && (cmd == CMD_WRITE);
  assign ps_wr_ok_s  = (state_q == ST_IDLE) || (state_q == ST_COMPLETE);
  assign wdog_inc_s  = wdog_q + 16'd1;

  // Next-state, watchdog and sticky error flags.
  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
`ifdef PL_MEM_BRIDGE_CLEAR_EN
    clr_addr_d = clr_addr_q;
`endif
    if (ps_wr_en && !ps_wr_ok_s) begin
      wr_err_d = 1'b1;
    end else begin
      wr_err_d = wr_err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (ps_start) begin
          state_d   = ST_ARMED;
          wr_err_d  = 1'b0;
          timeout_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if ((cmd == CMD_READ) || (cmd == CMD_WRITE)) begin
          state_d = ST_SERVING;
          wdog_d  = 16'd0;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_SERVING: begin
        wdog_d = wdog_inc_s;
        // done_pl outranks a watchdog expiry landing in the same cycle.
        if (done_pl) begin
          state_d = ST_COMPLETE;
        end else if (wdog_inc_s == TIMEOUT_W) begin
          state_d   = ST_COMPLETE;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_SERVING;
        end
      end
      ST_COMPLETE: begin
        if (ps_ack) begin
`ifdef PL_MEM_BRIDGE_CLEAR_EN
          state_d    = ST_CLEAR;
          clr_addr_d = 8'd0;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_COMPLETE;
        end
      end
`ifdef PL_MEM_BRIDGE_CLEAR_EN
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 8'd1;
        if (clr_addr_q == 8'hFF) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Busy covers every state in which the memory is owned by the PL or the sweep.
  always_comb begin
    busy_d = (state_d == ST_ARMED) || (state_d == ST_SERVING);
`ifdef PL_MEM_BRIDGE_CLEAR_EN
    if (state_d == ST_CLEAR) begin
      busy_d = 1'b1;
    end else begin
      busy_d = (state_d == ST_ARMED) || (state_d == ST_SERVING);
    end
`endif
  end

  // Single write port: owners are mutually exclusive by state; reset discards the write.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = 8'd0;
    mem_wdata_s = 32'd0;
    if (!rst) begin
      mem_we_s = 1'b0;
    end else if (ps_wr_en && ps_wr_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = ps_addr;
      mem_wdata_s = ps_wdata;
    end else if (pl_wr_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = address_pl;
      mem_wdata_s = data_pl;
`ifdef PL_MEM_BRIDGE_CLEAR_EN
    end else if (state_q == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_q;
      mem_wdata_s = 32'd0;
`endif
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // FSM state register with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      wdog_q         <= 16'd0;
      timeout_q      <= 1'b0;
      wr_err_q       <= 1'b0;
      busy_q         <= 1'b0;
      ready_q        <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef PL_MEM_BRIDGE_CLEAR_EN
      clr_addr_q     <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      wdog_q         <= wdog_d;
      timeout_q      <= timeout_d;
      wr_err_q       <= wr_err_d;
      busy_q         <= busy_d;
      ready_q        <= (state_d == ST_ARMED);
      result_valid_q <= (state_d == ST_COMPLETE);
`ifdef PL_MEM_BRIDGE_CLEAR_EN
      clr_addr_q     <= clr_addr_d;
`endif
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Registered read ports sample the pre-write contents (read-before-write).
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_in_q     <= 32'd0;
      ps_rdata_q    <= 32'd0;
      ps_rd_valid_q <= 1'b0;
    end else begin
      ps_rd_valid_q <= ps_rd_en;
      if (ps_rd_en) begin
        ps_rdata_q <= mem_q[ps_addr];
      end
      if (pl_rd_s) begin
        data_in_q <= mem_q[address_pl];
      end
    end
  end

  assign data_in     = data_in_q;
  assign ready       = ready_q;
  assign ps_rdata    = ps_rdata_q;
  assign ps_rd_valid = ps_rd_valid_q;
  assign status      = {busy_q, result_valid_q, timeout_q, wr_err_q};

endmodule

// File: tb/tb_pl_mem_bridge.sv
// Self-checking bench for pl_mem_bridge: directed scenarios plus randomized traffic compared
// every cycle against a job-level model of the shared memory and handshake.
module tb_pl_mem_bridge;

  localparam int TO = 8;
`ifdef PL_MEM_BRIDGE_CLEAR_EN
  localparam int EXP_CLR = 256;
`else
  localparam int EXP_CLR = 0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_SERV  = 2;
  localparam int P_DONE  = 3;
  localparam int P_CLR   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cmd;
  logic [7:0]  address_pl;
  logic [31:0] data_pl;
  logic        done_pl;
  logic [31:0] data_in;
  logic        ready;
  logic        ps_wr_en;
  logic        ps_rd_en;
  logic [7:0]  ps_addr;
  logic [31:0] ps_wdata;
  logic        ps_start;
  logic        ps_ack;
  logic [31:0] ps_rdata;
  logic        ps_rd_valid;
  logic [3:0]  status;

  always #5 clk = ~clk;

  pl_mem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .address_pl(address_pl), .data_pl(data_pl),
    .done_pl(done_pl), .data_in(data_in), .ready(ready), .ps_wr_en(ps_wr_en),
    .ps_rd_en(ps_rd_en), .ps_addr(ps_addr), .ps_wdata(ps_wdata), .ps_start(ps_start),
    .ps_ack(ps_ack), .ps_rdata(ps_rdata), .ps_rd_valid(ps_rd_valid), .status(status)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [31:0] m_mem [256];
  int          m_ph  = P_IDLE;
  int          m_wd  = 0;
  int          m_clr = 0;
  logic [31:0] m_din = 32'd0;
  logic [31:0] m_prd = 32'd0;
  logic        m_pv  = 1'b0;
  logic        m_to  = 1'b0;
  logic        m_we  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Job-level model: advance one clock using the inputs currently driven.
  task automatic model_step();
    bit pl_act;
    if (!rst) begin
      m_ph = P_IDLE; m_din = 32'd0; m_prd = 32'd0; m_pv = 1'b0;
      m_to = 1'b0; m_we = 1'b0; m_wd = 0;
      return;
    end
    m_pv = ps_rd_en;
    if (ps_rd_en) m_prd = m_mem[ps_addr];
    pl_act = (m_ph == P_ARMED) || (m_ph == P_SERV);
    if (pl_act && cmd == 3'd3) m_din = m_mem[address_pl];
    if (ps_wr_en) begin
      if (m_ph == P_IDLE || m_ph == P_DONE) m_mem[ps_addr] = ps_wdata;
      else m_we = 1'b1;
    end
    if (pl_act && cmd == 3'd2) m_mem[address_pl] = data_pl;
    case (m_ph)
      P_IDLE:  if (ps_start) begin m_ph = P_ARMED; m_we = 1'b0; m_to = 1'b0; end
      P_ARMED: if (cmd == 3'd2 || cmd == 3'd3) begin m_ph = P_SERV; m_wd = 0; end
      P_SERV: begin
        m_wd++;
        if (done_pl) m_ph = P_DONE;
        else if (m_wd == TO) begin m_ph = P_DONE; m_to = 1'b1; end
      end
      P_DONE: if (ps_ack) begin
`ifdef PL_MEM_BRIDGE_CLEAR_EN
        m_ph = P_CLR; m_clr = 0;
`else
        m_ph = P_IDLE;
`endif
      end
      P_CLR: begin
        m_mem[m_clr] = 32'd0;
        if (m_clr == 255) m_ph = P_IDLE;
        m_clr++;
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic tick();
    logic busy_e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    busy_e = (m_ph == P_ARMED) || (m_ph == P_SERV) || (m_ph == P_CLR);
    chk("data_in", data_in, m_din);
    chk("ready", {31'd0, ready}, {31'd0, m_ph == P_ARMED});
    chk("status", {28'd0, status}, {28'd0, busy_e, m_ph == P_DONE, m_to, m_we});
    chk("ps_rd_valid", {31'd0, ps_rd_valid}, {31'd0, m_pv});
    chk("ps_rdata", ps_rdata, m_prd);
  endtask

  task automatic idle_in();
    rst = 1'b1; cmd = 3'd4; address_pl = 8'd0; data_pl = 32'd0; done_pl = 1'b0;
    ps_wr_en = 1'b0; ps_rd_en = 1'b0; ps_addr = 8'd0; ps_wdata = 32'd0;
    ps_start = 1'b0; ps_ack = 1'b0;
  endtask

  task automatic ps_write(input logic [7:0] a, input logic [31:0] d);
    ps_wr_en = 1'b1; ps_addr = a; ps_wdata = d; tick(); ps_wr_en = 1'b0;
  endtask

  task automatic ps_read(input logic [7:0] a);
    ps_rd_en = 1'b1; ps_addr = a; tick(); ps_rd_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && m_ph != P_IDLE; i++) tick();
  endtask

  initial begin
    int busy_cnt;
    idle_in();
    rst = 1'b0;
    tick(); tick();
    chk("reset_status", {28'd0, status}, 32'd0);
    chk("reset_data_in", data_in, 32'd0);
    rst = 1'b1;
    for (int a = 0; a < 256; a++) ps_write(8'(a), $urandom);

    // Load operands and start; first PL read.
    ps_write(8'd255, 32'h87654321);
    ps_write(8'd254, 32'h00000005);
    ps_write(8'd253, 32'h00000001);
    ps_start = 1'b1; tick(); ps_start = 1'b0;
    chk("armed_ready", {31'd0, ready}, 32'd1);
    chk("armed_status", {28'd0, status}, 32'h8);
    cmd = 3'd3; address_pl = 8'd255; tick();
    chk("pl_read_255", data_in, 32'h87654321);
    chk("serving_ready", {31'd0, ready}, 32'd0);

    // PL write then done; PS reads back.
    cmd = 3'd2; address_pl = 8'd1; data_pl = 32'h64; done_pl = 1'b1; tick();
    cmd = 3'd4; done_pl = 1'b0;
    chk("complete_status", {28'd0, status}, 32'h4);
    ps_read(8'd1);
    chk("ps_read_1", ps_rdata, 32'h64);
    chk("ps_read_1_valid", {31'd0, ps_rd_valid}, 32'd1);
    ps_ack = 1'b1; tick(); ps_ack = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 300 && status[3]; i++) begin busy_cnt++; tick(); end
    chk("clear_busy_cycles", 32'(busy_cnt), 32'(EXP_CLR));
    ps_read(8'd255);
    chk("post_ack_255", ps_rdata, (EXP_CLR != 0) ? 32'd0 : 32'h87654321);

    // PS write while SERVING is dropped and flagged.
    ps_write(8'd10, 32'h12345678);
    ps_start = 1'b1; tick(); ps_start = 1'b0;
    cmd = 3'd3; address_pl = 8'd0; tick(); cmd = 3'd4;
    ps_write(8'd10, 32'hAA);
    chk("wr_err_set", {28'd0, status}, 32'h9);
    done_pl = 1'b1; tick(); done_pl = 1'b0;
    ps_read(8'd10);
    chk("mem10_kept", ps_rdata, 32'h12345678);
    ps_ack = 1'b1; tick(); ps_ack = 1'b0; wait_idle();
    ps_start = 1'b1; tick(); ps_start = 1'b0;
    chk("wr_err_cleared", {28'd0, status}, 32'h8);

    // Watchdog expiry after TO serving cycles.
    cmd = 3'd3; tick(); cmd = 3'd4;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("wdog_not_yet", {31'd0, status[2]}, 32'd0);
    tick();
    chk("wdog_expired", {28'd0, status}, 32'h6);
    ps_ack = 1'b1; tick(); ps_ack = 1'b0; wait_idle();

    // done_pl on the final watchdog cycle wins.
    ps_start = 1'b1; tick(); ps_start = 1'b0;
    cmd = 3'd3; tick(); cmd = 3'd4;
    for (int i = 0; i < TO - 1; i++) tick();
    done_pl = 1'b1; tick(); done_pl = 1'b0;
    chk("done_beats_wdog", {28'd0, status}, 32'h4);
    ps_ack = 1'b1; tick(); ps_ack = 1'b0; wait_idle();

    // Back-to-back PL read/write on addr 5, plus same-cycle PS read.
    ps_write(8'd5, 32'h11);
    ps_start = 1'b1; tick(); ps_start = 1'b0;
    cmd = 3'd3; address_pl = 8'd5; tick();
    chk("rbw_pl_read", data_in, 32'h11);
    cmd = 3'd2; data_pl = 32'h22; ps_rd_en = 1'b1; ps_addr = 8'd5; tick();
    ps_rd_en = 1'b0; cmd = 3'd4;
    chk("rbw_ps_old", ps_rdata, 32'h11);
    ps_read(8'd5);
    chk("rbw_ps_new", ps_rdata, 32'h22);
    done_pl = 1'b1; tick(); done_pl = 1'b0;
    ps_ack = 1'b1; tick(); ps_ack = 1'b0; wait_idle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst = ($urandom_range(0, 149) != 0);
      r = int'($urandom_range(0, 9));
      cmd = (r < 3) ? 3'd3 : (r < 6) ? 3'd2 : (r < 9) ? 3'd4 : 3'($urandom_range(0, 7));
      address_pl = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      data_pl    = $urandom;
      done_pl    = ($urandom_range(0, 11) == 0);
      ps_wr_en   = ($urandom_range(0, 2) == 0);
      ps_rd_en   = $urandom_range(0, 1) != 0;
      ps_addr    = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      ps_wdata   = $urandom;
      ps_start   = ($urandom_range(0, 5) == 0);
      ps_ack     = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
